// File: rtl/t_stream_unpacker.sv
// t_stream_unpacker: turns packed T-sequence SRAM words into a valid/ready character stream.
// Optional T_UNPACK_PREFETCH_EN adds a spare word buffer so word changes need no bubble.
module t_stream_unpacker #(
   parameter int  IDX_W  = 8,
   parameter int  SLOTS  = 7,
   parameter int  SIZE_W = 10,
   localparam int SLOT_W = 2 + 2*IDX_W,
   localparam int WORD_W = 4 + SLOTS*SLOT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [SIZE_W-1:0] i_T_size,
   output logic              o_sram_request,
   input  logic [WORD_W-1:0] i_sram_data,
   output logic              o_t_valid,
   input  logic              i_pe_ready,
   output logic [1:0]        o_t_char,
   output logic [IDX_W-1:0]  o_t_v,
   output logic [IDX_W-1:0]  o_t_f,
   output logic              o_t_last,
   output logic              o_busy,
   output logic              o_done
);

   // state   | meaning
   // S_IDLE  | waiting for i_start
   // S_FETCH | requesting a word from the SRAM controller
   // S_EMIT  | presenting buffer slot r_ptr to the PE array
   // S_DONE  | one-cycle completion pulse
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

   state_t              r_state, w_state_nx;
   logic [SIZE_W-1:0]   r_remaining;
   logic [SLOT_W-1:0]   r_buf [SLOTS];
   logic [2:0]          r_n;
   logic [2:0]          r_ptr;

   logic [SLOT_W-1:0]   w_in_slots [SLOTS];
   logic [2:0]          w_hdr_n;
   logic [3:0]          w_hdr_n_wide;
   logic [2:0]          w_in_n;
   logic                w_word_ok;
   logic                w_req;
   logic                w_load_cur;
   logic                w_xfer;
   logic                w_word_end;
   logic                w_rem_last;
   logic [SLOT_W-1:0]   w_cur;

`ifdef T_UNPACK_PREFETCH_EN
   logic [SLOT_W-1:0]   r_spare [SLOTS];
   logic [2:0]          r_spare_n;
   logic                r_spare_full;
   logic                w_swap;
   logic                w_load_spare;
   logic [SIZE_W-1:0]   w_left_ext;

   assign w_left_ext = {{(SIZE_W-3){1'b0}}, r_n - r_ptr};
`endif

   always_comb begin
      for (int k = 0; k < SLOTS; k++) begin
         w_in_slots[k] = i_sram_data[WORD_W-5-k*SLOT_W -: SLOT_W];
      end
   end

   // Header counts above SLOTS are clamped to a full word.
   assign w_hdr_n      = i_sram_data[WORD_W-2 -: 3];
   assign w_hdr_n_wide = {1'b0, w_hdr_n};
   assign w_in_n       = (w_hdr_n_wide > 4'(SLOTS)) ? 3'(SLOTS) : w_hdr_n;
   assign w_word_ok    = i_sram_data[WORD_W-1];

   assign w_xfer     = (r_state == S_EMIT) && i_pe_ready;
   assign w_word_end = ((r_ptr + 3'd1) == r_n);
   assign w_rem_last = (r_remaining == SIZE_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_req      = 1'b0;
      w_load_cur = 1'b0;
`ifdef T_UNPACK_PREFETCH_EN
      w_swap       = 1'b0;
      w_load_spare = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nx = (i_T_size == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH: begin
            w_req      = 1'b1;
            w_load_cur = w_word_ok && (w_in_n != 3'd0);
            if (w_load_cur) w_state_nx = S_EMIT;
         end
         S_EMIT: begin
`ifdef T_UNPACK_PREFETCH_EN
            w_req = !r_spare_full && (r_remaining > w_left_ext);
`endif
            if (w_xfer) begin
               if (w_rem_last) begin
                  w_state_nx = S_DONE;
               end else if (w_word_end) begin
`ifdef T_UNPACK_PREFETCH_EN
                  // A word arriving on the exhausting cycle goes straight into the current buffer.
                  if (r_spare_full)                                  w_swap     = 1'b1;
                  else if (w_req && w_word_ok && (w_in_n != 3'd0))   w_load_cur = 1'b1;
                  else                                               w_state_nx = S_FETCH;
`else
                  w_state_nx = S_FETCH;
`endif
               end
            end
`ifdef T_UNPACK_PREFETCH_EN
            w_load_spare = w_req && w_word_ok && (w_in_n != 3'd0) && !w_load_cur;
`endif
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_remaining <= '0;
         r_buf       <= '{default: '0};
         r_n         <= '0;
         r_ptr       <= '0;
      end else begin
         if ((r_state == S_IDLE) && i_start) r_remaining <= i_T_size;
         else if (w_xfer)                    r_remaining <= r_remaining - 1'b1;

         if (w_load_cur) begin
            r_buf <= w_in_slots;
            r_n   <= w_in_n;
            r_ptr <= '0;
`ifdef T_UNPACK_PREFETCH_EN
         end else if (w_swap) begin
            r_buf <= r_spare;
            r_n   <= r_spare_n;
            r_ptr <= '0;
`endif
         end else if (w_xfer) begin
            r_ptr <= r_ptr + 3'd1;
         end
      end
   end

`ifdef T_UNPACK_PREFETCH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_spare      <= '{default: '0};
         r_spare_n    <= '0;
         r_spare_full <= 1'b0;
      end else if (w_load_spare) begin
         r_spare      <= w_in_slots;
         r_spare_n    <= w_in_n;
         r_spare_full <= 1'b1;
      end else if (w_swap || (r_state == S_DONE)) begin
         r_spare_full <= 1'b0;
      end
   end
`endif

   assign w_cur          = r_buf[r_ptr];
   assign o_sram_request = w_req;
   assign o_t_valid      = (r_state == S_EMIT);
   assign o_t_char       = o_t_valid ? w_cur[SLOT_W-1 -: 2]      : 2'b00;
   assign o_t_v          = o_t_valid ? w_cur[2*IDX_W-1 -: IDX_W] : '0;
   assign o_t_f          = o_t_valid ? w_cur[IDX_W-1:0]          : '0;
   assign o_t_last       = o_t_valid && w_rem_last;
   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = (r_state == S_DONE);

endmodule
